// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder built on one fourBitAdder, one nibble per cycle.
// Define ADDER_SUB_EN to add the sub port (a - b as a + ~b + 1).
module fourBitAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic c1, c2, c3;

  assign s[0] = a[0] ^ b[0] ^ ci;
  assign c1   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign c2   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  assign s[2] = a[2] ^ b[2] ^ c2;
  assign c3   = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
  assign s[3] = a[3] ^ b[3] ^ c3;
  assign co   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, nstate;

  logic [WIDTH-1:0] opa, opb, sumr;
  logic [WIDTH-1:0] bsel;
  logic             csel;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             last;
  logic [3:0]       na, nb, ns;
  logic             nco;

`ifdef ADDER_SUB_EN
  assign bsel = sub ? ~b : b;
  assign csel = sub | cin;
`else
  assign bsel = b;
  assign csel = cin;
`endif

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == IW'(NIB - 1));

  // Current nibble of each operand, selected by the running index.
  assign na = 4'(opa >> {idx, 2'b00});
  assign nb = 4'(opb >> {idx, 2'b00});

  fourBitAdder u_add (
    .a (na),
    .b (nb),
    .ci(carry),
    .s (ns),
    .co(nco)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (in_valid) nstate = ADD;
      ADD:  if (last) nstate = DONE;
      DONE: if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      sumr  <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      opa   <= a;
      opb   <= bsel;
      sumr  <= '0;
      carry <= csel;
      idx   <= '0;
    end else if (state == ADD) begin
      carry <= nco;
      for (int i = 0; i < NIB; i++) begin
        if (idx == IW'(i)) sumr[4*i +: 4] <= ns;
      end
      // Index parks on the top nibble; it is reloaded on the next accept.
      if (!last) idx <= idx + 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sumr;
  assign cout      = carry;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16 and WIDTH=8).
// Subtract vectors run only when ADDER_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin, sb;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, busy;
  logic [15:0] sum;

  logic       v8, or8, c8, sb8;
  logic [7:0] a8, b8;
  logic       ir8, ov8, co8, busy8;
  logic [7:0] s8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef ADDER_SUB_EN
    .sub      (sb),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
  );

  nibble_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v8),
    .in_ready (ir8),
    .a        (a8),
    .b        (b8),
    .cin      (c8),
`ifdef ADDER_SUB_EN
    .sub      (sb8),
`endif
    .out_valid(ov8),
    .out_ready(or8),
    .sum      (s8),
    .cout     (co8),
    .busy     (busy8)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accept one operation, wait for out_valid, check latency/sum/cout.
  task automatic run_op(input string tag, input logic [15:0] ta,
                        input logic [15:0] tb, input logic tc,
                        input logic ts, input logic [15:0] es,
                        input logic ec);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1);
    a = ta; b = tb; cin = tc; sb = ts; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hdead; b = 16'hbeef; cin = 1'b0; sb = 1'b0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_busy"}, busy, 1);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_ovlo"}, out_valid, 0);
      @(negedge clk);
      check({tag, "_irhi"}, in_ready, 1);
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sb = 1'b0;
    v8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; c8 = 1'b0; sb8 = 1'b0;
    #12;
    check("rst_ir", in_ready, 1);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic, with in_ready timing checked inside run_op.
    run_op("basic", 16'h0005, 16'h0009, 1'b0, 1'b0, 16'h000e, 1'b0);
    run_op("ripple", 16'hffff, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("cin", 16'h0fff, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0);
    run_op("top", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("allone", 16'hffff, 16'hffff, 1'b1, 1'b0, 16'hffff, 1'b1);
    run_op("mix", 16'h3a7c, 16'h4596, 1'b0, 1'b0, 16'h8012, 1'b0);

    // Backpressure: DONE holds, second request ignored.
    out_ready = 1'b0;
    run_op("bp", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; a = 16'h0101; b = 16'h0202;
      end
      @(negedge clk);
      check("bp_hold_sum", sum, 16'h2345);
      check("bp_hold_ov", out_valid, 1);
      check("bp_hold_ir", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_ov", out_valid, 0);
    check("bp_rel_ir", in_ready, 1);
    repeat (6) @(negedge clk);
    check("bp_one_ov", out_valid, 0);
    check("bp_one_busy", busy, 0);
    check("bp_one_sum", sum, 16'h2345);

    // Reset during the second ADD cycle.
    a = 16'h7777; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mr_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("mr_ov", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_ir", in_ready, 1);
    check("mr_sum", sum, 0);
    check("mr_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

`ifdef ADDER_SUB_EN
    run_op("sub_neg", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hfffe, 1'b0);
    run_op("sub_pos", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1);
    run_op("add_again", 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0);
`endif

    // WIDTH=8 instance: latency 2.
    @(negedge clk);
    check("w8_rdy", ir8, 1);
    a8 = 8'hf0; b8 = 8'h10; v8 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    v8 = 1'b0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w8_lat", lat, 2);
    check("w8_sum", s8, 8'h00);
    check("w8_cout", co8, 1);
    @(negedge clk);
    @(negedge clk);
    check("w8_irhi", ir8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
